// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, entry type and constants for the write-back merge stage
package wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - in-order FIFO for FP results that lost write-port arbitration
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  wb_entry_t                     push_entry,
    input  logic                          pop,
    output wb_entry_t                     head,
    output logic [CNT_W-1:0]              count,
    output logic [DEPTH-1:0]              valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]  entry_rd
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: validity comes purely from pointers and count.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_entry;
    end

    assign head = mem[rd_ptr];

    // Entry i is live when its distance from the head is below the count.
    always_comb begin
        valid    = '0;
        entry_rd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid[i]    = {1'b0, PTR_W'(i) - rd_ptr} < count;
            entry_rd[i] = mem[i].rd;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - merges integer and FP results onto the register file write port
module wb_arbiter #(
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int ADDR_W = wb_pkg::ADDR_W,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              int_valid,
    input  logic [ADDR_W-1:0] int_rd,
    input  logic [DATA_W-1:0] int_data,
    input  logic              fp_valid,
    output logic              fp_ready,
    input  logic [ADDR_W-1:0] fp_rd,
    input  logic [DATA_W-1:0] fp_data,
    output logic              regWrite,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] query_rd,
    output logic              query_hit,
    output logic [CNT_W-1:0]  fifo_count
);

    wb_pkg::wb_entry_t            head;
    wb_pkg::wb_entry_t            fp_entry;
    logic [DEPTH-1:0]             fifo_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] fifo_rd;
    logic                         ready_en;
    logic                         int_ok;
    logic                         fp_keep;
    logic                         fifo_empty;
    logic                         push;
    logic                         pop;

    // Holds fp_ready low through reset and releases it on the first edge after.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ready_en <= 1'b0;
        else
            ready_en <= 1'b1;
    end

    assign fp_ready   = ready_en && (fifo_count < CNT_W'(DEPTH));
    assign int_ok     = int_valid && (int_rd != wb_pkg::REG_ZERO);
    assign fp_keep    = fp_valid && fp_ready && (fp_rd != wb_pkg::REG_ZERO);
    assign fifo_empty = (fifo_count == '0);
    assign push       = fp_keep && (int_ok || !fifo_empty);
    assign pop        = !int_ok && !fifo_empty;
    assign fp_entry   = '{rd: fp_rd, data: fp_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (fp_entry),
        .pop        (pop),
        .head       (head),
        .count      (fifo_count),
        .valid      (fifo_valid),
        .entry_rd   (fifo_rd)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regWrite  <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
        end else begin
            regWrite <= int_ok || !fifo_empty || fp_keep;
            if (int_ok) begin
                writeReg  <= int_rd;
                writeData <= int_data;
            end else if (!fifo_empty) begin
                writeReg  <= head.rd;
                writeData <= head.data;
            end else if (fp_keep) begin
                writeReg  <= fp_rd;
                writeData <= fp_data;
            end
        end
    end

    always_comb begin
        query_hit = fp_keep && (fp_rd == query_rd);
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_valid[i] && (fifo_rd[i] == query_rd))
                query_hit = 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed vector bench for wb_arbiter
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        int_valid;
    logic [4:0]  int_rd;
    logic [31:0] int_data;
    logic        fp_valid;
    logic        fp_ready;
    logic [4:0]  fp_rd;
    logic [31:0] fp_data;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [4:0]  query_rd;
    logic        query_hit;
    logic [2:0]  fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .int_valid  (int_valid),
        .int_rd     (int_rd),
        .int_data   (int_data),
        .fp_valid   (fp_valid),
        .fp_ready   (fp_ready),
        .fp_rd      (fp_rd),
        .fp_data    (fp_data),
        .regWrite   (regWrite),
        .writeReg   (writeReg),
        .writeData  (writeData),
        .query_rd   (query_rd),
        .query_hit  (query_hit),
        .fifo_count (fifo_count)
    );

    typedef struct {
        logic        iv;
        logic [4:0]  ird;
        logic [31:0] idat;
        logic        fv;
        logic [4:0]  frd;
        logic [31:0] fdat;
        logic [4:0]  qrd;
        logic        e_rdy;
        logic        e_hit;
        logic        e_rw;
        logic [4:0]  e_wr;
        logic [31:0] e_wd;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic iv, input logic [4:0] ird, input logic [31:0] idat,
                       input logic fv, input logic [4:0] frd, input logic [31:0] fdat,
                       input logic [4:0] qrd, input logic e_rdy, input logic e_hit,
                       input logic e_rw, input logic [4:0] e_wr, input logic [31:0] e_wd,
                       input logic [2:0] e_cnt);
        vec_t v;
        v = '{iv, ird, idat, fv, frd, fdat, qrd, e_rdy, e_hit, e_rw, e_wr, e_wd, e_cnt};
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        int_valid = 1'b0; int_rd = '0; int_data = '0;
        fp_valid  = 1'b0; fp_rd  = '0; fp_data  = '0;
        query_rd  = '0;
    endtask

    initial begin
        drive_idle();
        reset = 1'b0;

        //  iv ird idat          fv frd fdat           qrd rdy hit rw wr  wd             cnt
        add(1, 5,  32'h0000_00AA, 0, 0,  32'h0,          0,  1,  0,  0, 0,  32'h0,          0);
        add(0, 0,  32'h0,         0, 0,  32'h0,          0,  1,  0,  1, 5,  32'h0000_00AA,  0);
        add(0, 0,  32'h0,         0, 0,  32'h0,          0,  1,  0,  0, 5,  32'h0000_00AA,  0);
        add(0, 0,  32'h0,         1, 7,  32'h3F80_0000,  7,  1,  1,  0, 5,  32'h0000_00AA,  0);
        add(0, 0,  32'h0,         0, 0,  32'h0,          7,  1,  0,  1, 7,  32'h3F80_0000,  0);
        add(0, 0,  32'h0,         0, 0,  32'h0,          0,  1,  0,  0, 7,  32'h3F80_0000,  0);
        add(1, 1,  32'h101,       1, 10, 32'hF0A,        0,  1,  0,  0, 7,  32'h3F80_0000,  0);
        add(1, 2,  32'h102,       1, 11, 32'hF0B,        0,  1,  0,  1, 1,  32'h101,        1);
        add(1, 3,  32'h103,       1, 12, 32'hF0C,        0,  1,  0,  1, 2,  32'h102,        2);
        add(1, 4,  32'h104,       1, 13, 32'hF0D,        0,  1,  0,  1, 3,  32'h103,        3);
        add(1, 5,  32'h105,       1, 14, 32'hF0E,        0,  0,  0,  1, 4,  32'h104,        4);
        add(1, 6,  32'h106,       1, 14, 32'hF0E,        0,  0,  0,  1, 5,  32'h105,        4);
        add(0, 0,  32'h0,         1, 14, 32'hF0E,        12, 0,  1,  1, 6,  32'h106,        4);
        add(0, 0,  32'h0,         1, 14, 32'hF0E,        0,  1,  0,  1, 10, 32'hF0A,        3);
        add(0, 0,  32'h0,         0, 0,  32'h0,          0,  1,  0,  1, 11, 32'hF0B,        3);
        add(0, 0,  32'h0,         0, 0,  32'h0,          0,  1,  0,  1, 12, 32'hF0C,        2);
        add(0, 0,  32'h0,         0, 0,  32'h0,          14, 1,  1,  1, 13, 32'hF0D,        1);
        add(0, 0,  32'h0,         0, 0,  32'h0,          14, 1,  0,  1, 14, 32'hF0E,        0);
        add(0, 0,  32'h0,         0, 0,  32'h0,          0,  1,  0,  0, 14, 32'hF0E,        0);
        add(1, 3,  32'h33,        1, 9,  32'h99,         9,  1,  1,  0, 14, 32'hF0E,        0);
        add(0, 0,  32'h0,         0, 0,  32'h0,          9,  1,  1,  1, 3,  32'h33,         1);
        add(0, 0,  32'h0,         0, 0,  32'h0,          9,  1,  0,  1, 9,  32'h99,         0);
        add(0, 0,  32'h0,         0, 0,  32'h0,          0,  1,  0,  0, 9,  32'h99,         0);
        add(1, 0,  32'h55,        1, 0,  32'h66,         0,  1,  0,  0, 9,  32'h99,         0);
        add(0, 0,  32'h0,         0, 0,  32'h0,          0,  1,  0,  0, 9,  32'h99,         0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset regWrite", 32'(regWrite), 32'h0);
        chk("reset writeReg", 32'(writeReg), 32'h0);
        chk("reset writeData", writeData, 32'h0);
        chk("reset fifo_count", 32'(fifo_count), 32'h0);
        chk("reset fp_ready", 32'(fp_ready), 32'h0);

        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vq.size(); i++) begin
            int_valid = vq[i].iv;  int_rd = vq[i].ird;  int_data = vq[i].idat;
            fp_valid  = vq[i].fv;  fp_rd  = vq[i].frd;  fp_data  = vq[i].fdat;
            query_rd  = vq[i].qrd;
            @(negedge clk);
            chk($sformatf("row%0d fp_ready", i),   32'(fp_ready),   32'(vq[i].e_rdy));
            chk($sformatf("row%0d query_hit", i),  32'(query_hit),  32'(vq[i].e_hit));
            chk($sformatf("row%0d regWrite", i),   32'(regWrite),   32'(vq[i].e_rw));
            chk($sformatf("row%0d writeReg", i),   32'(writeReg),   32'(vq[i].e_wr));
            chk($sformatf("row%0d writeData", i),  writeData,       vq[i].e_wd);
            chk($sformatf("row%0d fifo_count", i), 32'(fifo_count), 32'(vq[i].e_cnt));
            @(posedge clk); #1;
        end

        // Fill three FIFO entries under integer priority, then reset mid-cycle.
        for (int k = 0; k < 3; k++) begin
            int_valid = 1'b1; int_rd = 5'(k + 1); int_data = 32'(k + 1);
            fp_valid  = 1'b1; fp_rd  = 5'(20 + k); fp_data = 32'hA00 + 32'(k);
            @(posedge clk); #1;
        end
        int_valid = 1'b1; int_rd = 5'd4; int_data = 32'h4;
        fp_valid  = 1'b0;
        @(negedge clk);
        chk("prefill fifo_count", 32'(fifo_count), 32'h3);
        chk("prefill regWrite", 32'(regWrite), 32'h1);
        #1 reset = 1'b0;
        #1;
        chk("async regWrite", 32'(regWrite), 32'h0);
        chk("async writeReg", 32'(writeReg), 32'h0);
        chk("async writeData", writeData, 32'h0);
        chk("async fifo_count", 32'(fifo_count), 32'h0);
        chk("async fp_ready", 32'(fp_ready), 32'h0);
        drive_idle();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("post-reset%0d regWrite", k), 32'(regWrite), 32'h0);
            chk($sformatf("post-reset%0d fifo_count", k), 32'(fifo_count), 32'h0);
            chk($sformatf("post-reset%0d fp_ready", k), 32'(fp_ready), 32'h1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
